atm_keypad_frontend: RTL and testbench
======================================

ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: inactivity limit in clk cycles for every waiting state except IDLE and WAIT_REMOVE.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset: sampled on rising clk, block resets while low.
REQ-004 card_detect  input  1  level, card physically present in reader.
REQ-005 card_pin  input  16  four BCD digits read from card, most significant digit first, valid while card_detect=1.
REQ-006 key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-007 key_code  input  4  0-9 digit, A ENTER, B CANCEL, C CLEAR, D BALANCE, E WITHDRAW, F ignored.
REQ-008 ctrl_state  input  3  controller state indicator: 0 IDLE … 7 EJECT_CARD.
REQ-009 card_inserted, pin_entered, pin_correct  output  1 each  session request bundle to controller.
REQ-010 transaction_choice  output  2  01 balance, 10 withdrawal, 00 none.
REQ-011 amount  output  16  withdrawal amount, unsigned binary.
REQ-012 fe_state  output  3  current front-end state encoding.
REQ-013 digit_count  output  3  digits held in the active entry buffer.
REQ-014 entry_error, timeout  output  1 each  one-cycle pulses.

Function
REQ-015 States/encoding: IDLE=0, PIN=1, MENU=2, AMOUNT=3, PRESENT=4, WAIT_REMOVE=5; 6,7 unused and SHALL go to IDLE next cycle.
REQ-016 IDLE: when card_detect=1, latch card_pin, clear buffers, go to PIN.
REQ-017 PIN: digit keys shift into 16-bit PIN buffer, digit_count+1; a 5th digit is ignored with entry_error pulse.
REQ-018 PIN: ENTER with digit_count=4 -> MENU, register pin_match = (buffer == latched card_pin), digit_count cleared; ENTER with fewer digits -> entry_error, stay.
REQ-019 CLEAR in PIN or AMOUNT clears that buffer and digit_count, no state change.
REQ-020 MENU: BALANCE -> choice=01, amount=0, go to PRESENT; digit key -> go to AMOUNT treating that key as first digit; WITHDRAW with amount=0 -> entry_error, stay.
REQ-021 AMOUNT: digit d gives amount = amount*10 + d computed in 20 bits; result >65535 or digit_count=5 -> key rejected, entry_error, amount unchanged.
REQ-022 AMOUNT: WITHDRAW with amount>0 -> choice=10, go to PRESENT; amount=0 -> entry_error; BALANCE -> entry_error.
REQ-023 ENTER in MENU/AMOUNT and non-digit keys not listed above -> entry_error, no other effect; key_code F ignored silently.
REQ-024 PRESENT: card_inserted=pin_entered=1, pin_correct=pin_match, transaction_choice and amount held constant every cycle, all asserted together on the first PRESENT cycle.
REQ-025 PRESENT exit: ctrl_state==7 -> WAIT_REMOVE; keys ignored in PRESENT.
REQ-026 Outside PRESENT: card_inserted, pin_entered, pin_correct=0, transaction_choice=00, amount=0.
REQ-027 CANCEL in PIN/MENU/AMOUNT -> WAIT_REMOVE, buffers cleared.
REQ-028 card_detect=0 in PIN/MENU/AMOUNT/PRESENT -> IDLE next cycle, all buffers cleared; this takes priority over any simultaneous key.
REQ-029 WAIT_REMOVE: stay until card_detect=0, then IDLE; no timeout.
REQ-030 Inactivity counter clears on state entry and every key_valid; reaching TIMEOUT_CYCLES in PIN/MENU/AMOUNT/PRESENT -> timeout pulse, WAIT_REMOVE.
REQ-031 key_valid with card_detect=0 in IDLE has no effect and no error.

Reset
REQ-032 While reset=0: state IDLE, all outputs 0, buffers, latched PIN, pin_match, counters 0; reset mid-PRESENT drops the bundle the following cycle.
REQ-033 First state change occurs on the first rising edge with reset=1.

Verification
REQ-034 card_pin=1234, keys 1,2,3,4,ENTER,BALANCE -> PRESENT with pin_correct=1, choice=01, amount=0; ctrl_state=7 -> WAIT_REMOVE; card removed -> IDLE.
REQ-035 card_pin=1234, keys 1,2,3,5,ENTER,2,5,0,WITHDRAW -> pin_correct=0, choice=10, amount=250.
REQ-036 Amount keys 6,5,5,3,6 -> amount 65536 rejected, entry_error, amount stays 6553; then 5 -> 65535 accepted; WITHDRAW with amount 0 -> entry_error.
REQ-037 PIN keys 1,2,ENTER -> entry_error, stay PIN; 5th digit -> entry_error; CLEAR -> digit_count=0.
REQ-038 TIMEOUT_CYCLES=8, no keys after card_detect -> timeout pulse on 8th PIN cycle, WAIT_REMOVE.
REQ-039 card_detect drops in AMOUNT concurrent with CANCEL key -> IDLE (not WAIT_REMOVE); reset=0 during PRESENT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/atm_keypad_frontend.sv
// rtl/atm_keypad_frontend.sv - ATM keypad front end: card, PIN, menu and amount capture feeding the session controller
module atm_keypad_frontend #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        card_detect,
    input  logic [15:0] card_pin,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [2:0]  ctrl_state,
    output logic        card_inserted,
    output logic        pin_entered,
    output logic        pin_correct,
    output logic [1:0]  transaction_choice,
    output logic [15:0] amount,
    output logic [2:0]  fe_state,
    output logic [2:0]  digit_count,
    output logic        entry_error,
    output logic        timeout
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PIN         = 3'd1,
        ST_MENU        = 3'd2,
        ST_AMOUNT      = 3'd3,
        ST_PRESENT     = 3'd4,
        ST_WAIT_REMOVE = 3'd5
    } state_t;

    localparam logic [3:0] KEY_ENTER    = 4'hA;
    localparam logic [3:0] KEY_CANCEL   = 4'hB;
    localparam logic [3:0] KEY_CLEAR    = 4'hC;
    localparam logic [3:0] KEY_BALANCE  = 4'hD;
    localparam logic [3:0] KEY_WITHDRAW = 4'hE;
    localparam logic [3:0] KEY_IGNORE   = 4'hF;

    localparam logic [2:0] CTRL_EJECT      = 3'd7;
    localparam logic [1:0] CHOICE_NONE     = 2'b00;
    localparam logic [1:0] CHOICE_BALANCE  = 2'b01;
    localparam logic [1:0] CHOICE_WITHDRAW = 2'b10;

    // Timer counts cycles already spent in the state; it never needs to exceed TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic [15:0]   pin_buf;
    logic [15:0]   pin_buf_next;
    logic [15:0]   card_pin_q;
    logic [15:0]   card_pin_next;
    logic          pin_match;
    logic          pin_match_next;
    logic [15:0]   amount_buf;
    logic [15:0]   amount_next;
    logic [1:0]    choice;
    logic [1:0]    choice_next;
    logic [2:0]    count;
    logic [2:0]    count_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;

    logic          err_c;
    logic          timeout_c;
    logic          is_digit;
    logic          timed;
    logic          timer_hit;
    logic [19:0]   amount_calc;

    // State and datapath registers; everything clears while reset is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pin_buf    <= '0;
            card_pin_q <= '0;
            pin_match  <= 1'b0;
            amount_buf <= '0;
            choice     <= CHOICE_NONE;
            count      <= '0;
            timer      <= '0;
        end else begin
            state      <= state_next;
            pin_buf    <= pin_buf_next;
            card_pin_q <= card_pin_next;
            pin_match  <= pin_match_next;
            amount_buf <= amount_next;
            choice     <= choice_next;
            count      <= count_next;
            timer      <= timer_next;
        end
    end

    // Next-state, buffer updates and error/timeout pulses; card removal outranks timeout, which outranks keys.
    always_comb begin
        state_next     = state;
        pin_buf_next   = pin_buf;
        card_pin_next  = card_pin_q;
        pin_match_next = pin_match;
        amount_next    = amount_buf;
        choice_next    = choice;
        count_next     = count;
        timer_next     = timer;
        err_c          = 1'b0;
        timeout_c      = 1'b0;

        is_digit    = (key_code <= 4'd9);
        timed       = state inside {ST_PIN, ST_MENU, ST_AMOUNT, ST_PRESENT};
        timer_hit   = timed && !key_valid && (timer == TIMER_LAST);
        amount_calc = ({4'd0, amount_buf} * 20'd10) + {16'd0, key_code};

        case (state)
            ST_IDLE: begin
                if (card_detect) begin
                    state_next    = ST_PIN;
                    card_pin_next = card_pin;
                    pin_buf_next  = '0;
                    amount_next   = '0;
                    count_next    = '0;
                    choice_next   = CHOICE_NONE;
                end
            end
            ST_PIN, ST_MENU, ST_AMOUNT, ST_PRESENT: begin
                if (!card_detect) begin
                    state_next = ST_IDLE;
                end else if (timer_hit) begin
                    timeout_c  = 1'b1;
                    state_next = ST_WAIT_REMOVE;
                end else if (state == ST_PRESENT) begin
                    if (ctrl_state == CTRL_EJECT) begin
                        state_next = ST_WAIT_REMOVE;
                    end
                end else if (key_valid && key_code != KEY_IGNORE) begin
                    if (key_code == KEY_CANCEL) begin
                        state_next = ST_WAIT_REMOVE;
                    end else if (state == ST_PIN) begin
                        if (is_digit) begin
                            if (count == 3'd4) begin
                                err_c = 1'b1;
                            end else begin
                                pin_buf_next = {pin_buf[11:0], key_code};
                                count_next   = count + 3'd1;
                            end
                        end else if (key_code == KEY_ENTER) begin
                            if (count == 3'd4) begin
                                state_next     = ST_MENU;
                                pin_match_next = (pin_buf == card_pin_q);
                                pin_buf_next   = '0;
                                count_next     = '0;
                            end else begin
                                err_c = 1'b1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            pin_buf_next = '0;
                            count_next   = '0;
                        end else begin
                            err_c = 1'b1;
                        end
                    end else if (state == ST_MENU) begin
                        if (is_digit) begin
                            state_next  = ST_AMOUNT;
                            amount_next = {12'd0, key_code};
                            count_next  = 3'd1;
                        end else if (key_code == KEY_BALANCE) begin
                            state_next  = ST_PRESENT;
                            choice_next = CHOICE_BALANCE;
                            amount_next = '0;
                            count_next  = '0;
                        end else begin
                            // Amount is always zero here, so WITHDRAW is an error too.
                            err_c = 1'b1;
                        end
                    end else begin
                        if (is_digit) begin
                            if (count == 3'd5 || amount_calc > 20'd65535) begin
                                err_c = 1'b1;
                            end else begin
                                amount_next = amount_calc[15:0];
                                count_next  = count + 3'd1;
                            end
                        end else if (key_code == KEY_WITHDRAW) begin
                            if (amount_buf != 16'd0) begin
                                state_next  = ST_PRESENT;
                                choice_next = CHOICE_WITHDRAW;
                                count_next  = '0;
                            end else begin
                                err_c = 1'b1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            amount_next = '0;
                            count_next  = '0;
                        end else begin
                            err_c = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_REMOVE: begin
                if (!card_detect) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Leaving a session for IDLE or WAIT_REMOVE wipes every session buffer.
        if (state_next != state && (state_next == ST_IDLE || state_next == ST_WAIT_REMOVE)) begin
            pin_buf_next   = '0;
            card_pin_next  = '0;
            pin_match_next = 1'b0;
            amount_next    = '0;
            choice_next    = CHOICE_NONE;
            count_next     = '0;
        end

        if (state_next != state || key_valid || !timed) begin
            timer_next = '0;
        end else begin
            timer_next = timer + 1'b1;
        end
    end

    assign card_inserted      = (state == ST_PRESENT);
    assign pin_entered        = (state == ST_PRESENT);
    assign pin_correct        = (state == ST_PRESENT) && pin_match;
    assign transaction_choice = (state == ST_PRESENT) ? choice : CHOICE_NONE;
    assign amount             = (state == ST_PRESENT) ? amount_buf : 16'd0;
    assign fe_state           = state;
    assign digit_count        = count;
    assign entry_error        = err_c & reset;
    assign timeout            = timeout_c & reset;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// tb/tb_atm_keypad_frontend.sv - scoreboard bench for atm_keypad_frontend
module tb_atm_keypad_frontend;

    localparam logic [3:0] K_ENTER    = 4'hA;
    localparam logic [3:0] K_CANCEL   = 4'hB;
    localparam logic [3:0] K_CLEAR    = 4'hC;
    localparam logic [3:0] K_BALANCE  = 4'hD;
    localparam logic [3:0] K_WITHDRAW = 4'hE;
    localparam logic [3:0] K_IGNORE   = 4'hF;

    typedef struct packed {
        logic        pc;
        logic [1:0]  ch;
        logic [15:0] amt;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        card_detect = 1'b0;
    logic [15:0] card_pin = 16'h0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [2:0]  ctrl_state = 3'd0;
    logic        card_inserted;
    logic        pin_entered;
    logic        pin_correct;
    logic [1:0]  transaction_choice;
    logic [15:0] amount;
    logic [2:0]  fe_state;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        timeout;

    int total = 0;
    int bad = 0;
    int bundles_seen = 0;
    bundle_t exp_q[$];
    bundle_t cur;
    bundle_t act;
    logic prev_ci = 1'b0;

    atm_keypad_frontend #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .card_detect(card_detect),
        .card_pin(card_pin),
        .key_valid(key_valid),
        .key_code(key_code),
        .ctrl_state(ctrl_state),
        .card_inserted(card_inserted),
        .pin_entered(pin_entered),
        .pin_correct(pin_correct),
        .transaction_choice(transaction_choice),
        .amount(amount),
        .fe_state(fe_state),
        .digit_count(digit_count),
        .entry_error(entry_error),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop an expected bundle when PRESENT starts, then require it held every PRESENT cycle.
    always @(negedge clk) begin
        if (reset === 1'b1 && card_inserted === 1'b1) begin
            act = {pin_correct, transaction_choice, amount};
            total++;
            if (!prev_ci) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bundle_unexpected got pc=%0b ch=%b amt=%0d want no bundle", act.pc, act.ch, act.amt);
                    cur = act;
                end else begin
                    cur = exp_q.pop_front();
                    if (act !== cur) begin
                        bad++;
                        $display("FAIL bundle_value got pc=%0b ch=%b amt=%0d want pc=%0b ch=%b amt=%0d",
                                 act.pc, act.ch, act.amt, cur.pc, cur.ch, cur.amt);
                    end
                end
                bundles_seen++;
            end else if (act !== cur) begin
                bad++;
                $display("FAIL bundle_hold got pc=%0b ch=%b amt=%0d want pc=%0b ch=%b amt=%0d",
                         act.pc, act.ch, act.amt, cur.pc, cur.ch, cur.amt);
            end
            total++;
            if (pin_entered !== 1'b1) begin
                bad++;
                $display("FAIL bundle_pin_entered got %b want 1", pin_entered);
            end
        end
        prev_ci = (card_inserted === 1'b1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] k, output logic err);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        err = entry_error;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic insert_card(input logic [15:0] p);
        card_pin    = p;
        card_detect = 1'b1;
        tick();
    endtask

    task automatic press_pin(input logic [15:0] p);
        logic e;
        press_key(p[15:12], e);
        press_key(p[11:8], e);
        press_key(p[7:4], e);
        press_key(p[3:0], e);
        press_key(K_ENTER, e);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        card_detect = 1'b1;
        card_pin = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (fe_state !== 3'd0) begin bad++; $display("FAIL rst_fe_state got %0d want 0", fe_state); end
        total++; if ({card_inserted, pin_entered, pin_correct} !== 3'b000) begin bad++; $display("FAIL rst_bundle got %b want 000", {card_inserted, pin_entered, pin_correct}); end
        total++; if ({transaction_choice, amount} !== 18'd0) begin bad++; $display("FAIL rst_choice_amount got %h want 0", {transaction_choice, amount}); end
        total++; if ({digit_count, entry_error, timeout} !== 5'd0) begin bad++; $display("FAIL rst_count_pulses got %b want 0", {digit_count, entry_error, timeout}); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total++; if (fe_state !== 3'd0) begin bad++; $display("FAIL rst_release_hold got %0d want 0", fe_state); end
        tick();
        total++; if (fe_state !== 3'd1) begin bad++; $display("FAIL rst_first_edge got %0d want 1", fe_state); end
        card_detect = 1'b0;
        tick();
        total++; if (fe_state !== 3'd0) begin bad++; $display("FAIL rst_remove got %0d want 0", fe_state); end
    endtask

    task automatic test_balance;
        logic e;
        int n0;
        exp_q.push_back('{pc: 1'b1, ch: 2'b01, amt: 16'd0});
        insert_card(16'h1234);
        press_pin(16'h1234);
        total++; if (fe_state !== 3'd2 || digit_count !== 3'd0) begin bad++; $display("FAIL bal_menu got state=%0d cnt=%0d want 2/0", fe_state, digit_count); end
        n0 = bundles_seen;
        press_key(K_BALANCE, e);
        for (int i = 0; i < 4 && bundles_seen == n0; i++) @(negedge clk);
        total++; if (bundles_seen != n0 + 1) begin bad++; $display("FAIL bal_bundle got %0d bundles want 1", bundles_seen - n0); end
        @(posedge clk);
        #1;
        press_key(4'd7, e);
        total++; if (fe_state !== 3'd4 || e !== 1'b0) begin bad++; $display("FAIL bal_key_ignored got state=%0d err=%b want 4/0", fe_state, e); end
        ctrl_state = 3'd7;
        tick();
        ctrl_state = 3'd0;
        total++; if (fe_state !== 3'd5 || card_inserted !== 1'b0) begin bad++; $display("FAIL bal_eject got state=%0d ci=%b want 5/0", fe_state, card_inserted); end
        tick();
        total++; if (fe_state !== 3'd5) begin bad++; $display("FAIL bal_wait_hold got %0d want 5", fe_state); end
        card_detect = 1'b0;
        tick();
        total++; if (fe_state !== 3'd0) begin bad++; $display("FAIL bal_idle got %0d want 0", fe_state); end
    endtask

    task automatic test_withdraw;
        logic e;
        int n0;
        exp_q.push_back('{pc: 1'b0, ch: 2'b10, amt: 16'd250});
        insert_card(16'h1234);
        press_pin(16'h1235);
        press_key(4'd2, e);
        press_key(4'd5, e);
        press_key(4'd0, e);
        total++; if (fe_state !== 3'd3 || digit_count !== 3'd3) begin bad++; $display("FAIL wd_amount_state got state=%0d cnt=%0d want 3/3", fe_state, digit_count); end
        total++; if (amount !== 16'd0 || card_inserted !== 1'b0 || transaction_choice !== 2'b00) begin bad++; $display("FAIL wd_outputs_idle got amt=%0d ci=%b ch=%b want 0/0/00", amount, card_inserted, transaction_choice); end
        n0 = bundles_seen;
        press_key(K_WITHDRAW, e);
        for (int i = 0; i < 4 && bundles_seen == n0; i++) @(negedge clk);
        total++; if (bundles_seen != n0 + 1) begin bad++; $display("FAIL wd_bundle got %0d bundles want 1", bundles_seen - n0); end
        @(posedge clk);
        #1;
        ctrl_state = 3'd7;
        tick();
        ctrl_state = 3'd0;
        card_detect = 1'b0;
        tick();
        total++; if (fe_state !== 3'd0) begin bad++; $display("FAIL wd_idle got %0d want 0", fe_state); end
    endtask

    task automatic test_amount_limit;
        logic e;
        logic any;
        int n0;
        insert_card(16'h9876);
        press_pin(16'h9876);
        press_key(K_WITHDRAW, e);
        total++; if (e !== 1'b1 || fe_state !== 3'd2) begin bad++; $display("FAIL lim_menu_withdraw got err=%b state=%0d want 1/2", e, fe_state); end
        press_key(4'd6, e);
        any = e;
        press_key(4'd5, e); any = any | e;
        press_key(4'd5, e); any = any | e;
        press_key(4'd3, e); any = any | e;
        total++; if (any !== 1'b0 || digit_count !== 3'd4) begin bad++; $display("FAIL lim_6553 got err=%b cnt=%0d want 0/4", any, digit_count); end
        press_key(4'd6, e);
        total++; if (e !== 1'b1 || digit_count !== 3'd4) begin bad++; $display("FAIL lim_65536 got err=%b cnt=%0d want 1/4", e, digit_count); end
        press_key(4'd5, e);
        total++; if (e !== 1'b0 || digit_count !== 3'd5) begin bad++; $display("FAIL lim_65535 got err=%b cnt=%0d want 0/5", e, digit_count); end
        press_key(4'd1, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL lim_sixth got err=%b want 1", e); end
        exp_q.push_back('{pc: 1'b1, ch: 2'b10, amt: 16'd65535});
        n0 = bundles_seen;
        press_key(K_WITHDRAW, e);
        for (int i = 0; i < 4 && bundles_seen == n0; i++) @(negedge clk);
        total++; if (bundles_seen != n0 + 1) begin bad++; $display("FAIL lim_bundle got %0d bundles want 1", bundles_seen - n0); end
        @(posedge clk);
        #1;
        ctrl_state = 3'd7;
        tick();
        ctrl_state = 3'd0;
        card_detect = 1'b0;
        tick();
    endtask

    task automatic test_digit_limit;
        logic e;
        int n0;
        insert_card(16'h0000);
        press_pin(16'h0000);
        press_key(4'd0, e);
        total++; if (fe_state !== 3'd3 || digit_count !== 3'd1 || e !== 1'b0) begin bad++; $display("FAIL dig_first got state=%0d cnt=%0d err=%b want 3/1/0", fe_state, digit_count, e); end
        press_key(K_WITHDRAW, e);
        total++; if (e !== 1'b1 || fe_state !== 3'd3) begin bad++; $display("FAIL dig_withdraw_zero got err=%b state=%0d want 1/3", e, fe_state); end
        press_key(K_ENTER, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL dig_enter got err=%b want 1", e); end
        press_key(K_BALANCE, e);
        total++; if (e !== 1'b1 || fe_state !== 3'd3) begin bad++; $display("FAIL dig_balance got err=%b state=%0d want 1/3", e, fe_state); end
        press_key(4'd0, e);
        press_key(4'd0, e);
        press_key(4'd0, e);
        press_key(4'd1, e);
        press_key(4'd2, e);
        total++; if (e !== 1'b1 || digit_count !== 3'd5) begin bad++; $display("FAIL dig_count5 got err=%b cnt=%0d want 1/5", e, digit_count); end
        exp_q.push_back('{pc: 1'b1, ch: 2'b10, amt: 16'd1});
        n0 = bundles_seen;
        press_key(K_WITHDRAW, e);
        for (int i = 0; i < 4 && bundles_seen == n0; i++) @(negedge clk);
        total++; if (bundles_seen != n0 + 1) begin bad++; $display("FAIL dig_bundle got %0d bundles want 1", bundles_seen - n0); end
        @(posedge clk);
        #1;
        card_detect = 1'b0;
        tick();
        total++; if (fe_state !== 3'd0 || card_inserted !== 1'b0) begin bad++; $display("FAIL dig_pull_present got state=%0d ci=%b want 0/0", fe_state, card_inserted); end
    endtask

    task automatic test_pin_entry;
        logic e;
        insert_card(16'h1234);
        press_key(4'd1, e);
        press_key(4'd2, e);
        press_key(K_ENTER, e);
        total++; if (e !== 1'b1 || fe_state !== 3'd1 || digit_count !== 3'd2) begin bad++; $display("FAIL pin_short_enter got err=%b state=%0d cnt=%0d want 1/1/2", e, fe_state, digit_count); end
        press_key(K_IGNORE, e);
        total++; if (e !== 1'b0 || digit_count !== 3'd2) begin bad++; $display("FAIL pin_key_f got err=%b cnt=%0d want 0/2", e, digit_count); end
        press_key(4'd3, e);
        press_key(4'd4, e);
        press_key(4'd5, e);
        total++; if (e !== 1'b1 || digit_count !== 3'd4) begin bad++; $display("FAIL pin_fifth got err=%b cnt=%0d want 1/4", e, digit_count); end
        press_key(K_CLEAR, e);
        total++; if (e !== 1'b0 || digit_count !== 3'd0 || fe_state !== 3'd1) begin bad++; $display("FAIL pin_clear got err=%b cnt=%0d state=%0d want 0/0/1", e, digit_count, fe_state); end
        press_pin(16'h1234);
        total++; if (fe_state !== 3'd2) begin bad++; $display("FAIL pin_retry got %0d want 2", fe_state); end
        press_key(K_CANCEL, e);
        total++; if (fe_state !== 3'd5 || e !== 1'b0) begin bad++; $display("FAIL pin_cancel got state=%0d err=%b want 5/0", fe_state, e); end
        card_detect = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        logic [7:0] seen;
        card_pin = 16'h4321;
        card_detect = 1'b1;
        seen = 8'h00;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            seen[k-1] = (timeout === 1'b1) && (fe_state === 3'd1);
        end
        total++; if (seen !== 8'h80) begin bad++; $display("FAIL to_pulse_cycles got %b want 10000000", seen); end
        @(posedge clk);
        #1;
        total++; if (fe_state !== 3'd5 || timeout !== 1'b0) begin bad++; $display("FAIL to_wait_remove got state=%0d to=%b want 5/0", fe_state, timeout); end
        repeat (10) @(negedge clk);
        total++; if (fe_state !== 3'd5 || timeout !== 1'b0) begin bad++; $display("FAIL to_wait_no_timeout got state=%0d to=%b want 5/0", fe_state, timeout); end
        @(posedge clk);
        #1;
        card_detect = 1'b0;
        tick();
    endtask

    task automatic test_card_pull;
        logic e;
        insert_card(16'h1234);
        press_pin(16'h1234);
        press_key(4'd5, e);
        card_detect = 1'b0;
        press_key(K_CANCEL, e);
        total++; if (fe_state !== 3'd0 || digit_count !== 3'd0) begin bad++; $display("FAIL pull_cancel got state=%0d cnt=%0d want 0/0", fe_state, digit_count); end
        press_key(4'd3, e);
        total++; if (e !== 1'b0 || fe_state !== 3'd0) begin bad++; $display("FAIL idle_key got err=%b state=%0d want 0/0", e, fe_state); end
    endtask

    task automatic test_reset_present;
        logic e;
        int n0;
        exp_q.push_back('{pc: 1'b1, ch: 2'b01, amt: 16'd0});
        insert_card(16'h5555);
        press_pin(16'h5555);
        n0 = bundles_seen;
        press_key(K_BALANCE, e);
        for (int i = 0; i < 4 && bundles_seen == n0; i++) @(negedge clk);
        total++; if (bundles_seen != n0 + 1) begin bad++; $display("FAIL rp_bundle got %0d bundles want 1", bundles_seen - n0); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        total++; if ({card_inserted, pin_entered, pin_correct, transaction_choice, amount, fe_state} !== 24'd0) begin bad++; $display("FAIL rp_drop got %h want 0", {card_inserted, pin_entered, pin_correct, transaction_choice, amount, fe_state}); end
        card_detect = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        total++; if (fe_state !== 3'd0) begin bad++; $display("FAIL rp_after got %0d want 0", fe_state); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_balance();
        test_withdraw();
        test_amount_limit();
        test_digit_limit();
        test_pin_entry();
        test_timeout();
        test_card_pull();
        test_reset_present();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
